// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: NREQ valid/ready requesters share one combinational adder
// through a round-robin grant; results land in a one-deep tagged response slot.

module adder #(
    parameter int n = 4
) (
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic [n-1:0] Sum,
    output logic         Cout
);
    assign {Cout, Sum} = {1'b0, A} + {1'b0, B};
endmodule

module adder_rr_arbiter #(
    parameter int n    = 4,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*n-1:0] req_a,
    input  logic [NREQ*n-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [n-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic [15:0]       ops_count
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] rr_ptr;
    logic           can_accept;
    logic           hi_found;
    logic           lo_found;
    logic [IDW-1:0] hi_idx;
    logic [IDW-1:0] lo_idx;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [n-1:0]   add_a;
    logic [n-1:0]   add_b;
    logic [n-1:0]   add_sum;
    logic           add_cout;

    // A full slot that drains this cycle frees room for a new result.
    assign can_accept = (state == EMPTY) | rsp_ready;

    // Round-robin search: first valid at/after rr_ptr, else first valid from 0.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && !hi_found && (IDW'(i) >= rr_ptr)) begin
                hi_found = 1'b1;
                hi_idx   = IDW'(i);
            end
            if (req_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = IDW'(i);
            end
        end
    end

    assign gnt_found = can_accept & rst_n & (hi_found | lo_found);
    assign gnt_idx   = hi_found ? hi_idx : lo_idx;

    // One-hot grant back to the chosen requester.
    always_comb begin
        req_ready = '0;
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Steer the granted operand pair into the shared adder; zeros when idle.
    always_comb begin
        add_a = '0;
        add_b = '0;
        if (gnt_found) begin
            add_a = req_a[gnt_idx*n +: n];
            add_b = req_b[gnt_idx*n +: n];
        end
    end

    adder #(.n(n)) u_adder (
        .A    (add_a),
        .B    (add_b),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    // Slot occupancy: a grant fills it, a drain with no grant empties it.
    always_comb begin
        state_next = state;
        if (gnt_found) begin
            state_next = FULL;
        end else if (state == FULL && rsp_ready) begin
            state_next = EMPTY;
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    assign rsp_valid = (state == FULL);

    // Capture the result, advance the pointer past the winner, count the op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rr_ptr    <= '0;
            ops_count <= '0;
        end else if (gnt_found) begin
            rsp_id   <= gnt_idx;
            rsp_sum  <= add_sum;
            rsp_cout <= add_cout;
            rr_ptr   <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            if (ops_count != 16'hFFFF) begin
                ops_count <= ops_count + 16'd1;
            end
        end
    end

endmodule
